// File: rtl/dsc_pkg.sv
// Shared types and helpers for the deterministic stochastic-computing multiplier.
package dsc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } dsc_mul_state_t;

   // Accumulator width: (2^W-1)^N always fits in N*W bits.
   function automatic int dsc_acc_width(input int n, input int w);
      return n * w;
   endfunction

   // Cycle count of a full-length run over every counter combination.
   function automatic longint unsigned dsc_run_len(input int n, input int w);
      return longint'(1) << (n * w);
   endfunction

endpackage

// File: rtl/dsc_cmp_sng.sv
// Comparator-based stream generator: counter plus magnitude compare; the
// synchronous wrap-enable chains the next generator without derived clocks.
module dsc_cmp_sng #(
   parameter int WIDTH = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en_in,
   input  logic [WIDTH-1:0] bin_in,
   output logic             sn_out,
   output logic             wrap_out
);

   logic [WIDTH-1:0] ctr_reg;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ctr_reg <= '0;
      end else if (en_in) begin
         ctr_reg <= ctr_reg + 1'b1;
      end
   end

   assign sn_out   = (ctr_reg < bin_in);
   assign wrap_out = en_in & (&ctr_reg);

endmodule

// File: rtl/dsc_sync_mul.sv
// Handshaked clock-division stochastic multiplier with exact binary product.
// Optional early termination: define DSC_SYNC_MUL_EARLY_TERM_EN.
module dsc_sync_mul
   import dsc_pkg::*;
#(
   parameter int DATA_WIDTH = 5,
   parameter int NUM_INPUTS = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NUM_INPUTS*DATA_WIDTH-1:0] bin_data_out,
   output logic                            busy
);

   localparam int ACC_W = dsc_acc_width(NUM_INPUTS, DATA_WIDTH);

   dsc_mul_state_t state_reg, state_next;

   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] x_reg;
   logic [ACC_W-1:0]                      acc_reg;
   logic [NUM_INPUTS-1:0]                 en;
   logic [NUM_INPUTS-1:0]                 sn;
   logic [NUM_INPUTS-1:0]                 wrap;
   logic                                  accept;
   logic                                  run_active;
   logic                                  last_cycle;

   assign accept     = (state_reg == IDLE) & in_valid;
   assign run_active = (state_reg == RUN);
   assign en[0]      = run_active;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_sng
         dsc_cmp_sng #(
            .WIDTH (DATA_WIDTH)
         ) u_sng (
            .clk      (clk),
            .rst      (rst),
            .clr      (accept),
            .en_in    (en[gi]),
            .bin_in   (x_reg[gi]),
            .sn_out   (sn[gi]),
            .wrap_out (wrap[gi])
         );
         if (gi > 0) begin : g_chain
            assign en[gi] = wrap[gi-1];
         end
      end
   endgenerate

`ifdef DSC_SYNC_MUL_EARLY_TERM_EN
   logic                  any_zero;
   logic [DATA_WIDTH-1:0] x_last_m1;
   logic                  sn_aux;
   logic                  wrap_aux;

   always_comb begin
      any_zero = 1'b0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (x_reg[i] == '0) begin
            any_zero = 1'b1;
         end
      end
   end

   // Shadow of the last counter compared against x-1: together with sn it
   // flags the cycle where the last counter sits at x-1, the final one bit.
   assign x_last_m1 = x_reg[NUM_INPUTS-1] - 1'b1;

   dsc_cmp_sng #(
      .WIDTH (DATA_WIDTH)
   ) u_sng_aux (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .en_in    (en[NUM_INPUTS-1]),
      .bin_in   (x_last_m1),
      .sn_out   (sn_aux),
      .wrap_out (wrap_aux)
   );

   assign last_cycle = run_active &
                       (any_zero | wrap[NUM_INPUTS-1] |
                        (en[NUM_INPUTS-1] & sn[NUM_INPUTS-1] & ~sn_aux & ~wrap_aux));
`else
   assign last_cycle = wrap[NUM_INPUTS-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         x_reg   <= '0;
         acc_reg <= '0;
      end else if (accept) begin
         x_reg   <= bin_data_in;
         acc_reg <= '0;
      end else if (run_active) begin
         acc_reg <= acc_reg + ACC_W'(&sn);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid)   state_next = RUN;
         RUN:     if (last_cycle) state_next = DONE;
         DONE:    if (out_ready)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_reg)
         IDLE:    in_ready  = 1'b1;
         RUN:     busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   assign bin_data_out = acc_reg;

endmodule
